mac_sequencer: RTL and testbench

- Sequences the per-PE multiply-accumulate datapath for one MULTACC instruction: C = A x B, with N x N operands, N = DIMEN+1 (1..4).
- PE p (0..3) holds row p of A and all of B in local register files. It produces row p of C.
- Issues operand read addresses, MAC enable, accumulator-clear and C write-back strobes through a read-latency-matched pipeline.
- Returns a single MAC_DONE pulse to the control unit.

---
 rtl/mac_sequencer_if.sv | 40 ++++
 rtl/mac_sequencer.sv | 130 +++++++++++++
 tb/tb_mac_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Control-unit <-> MAC sequencer bundle.
//   master : control unit side (drives START/DIMEN/STALL, observes sequencer outputs)
//   slave  : sequencer side
// Signals:
//   START      one-cycle MULTACC request
//   DIMEN      matrix dimension code, N = DIMEN+1
//   STALL      freezes the sequencer and its pipeline
//   RD_ADDR_A  A-row element index k
//   RD_ADDR_B  B element address k*4+j
//   MAC_EN     per-PE MAC enable
//   ACC_CLR    accumulator load (instead of add) qualifier for MAC_EN
//   WR_ADDR_C  C column index being written
//   WR_EN_C    per-PE C write strobe
//   BUSY       sequence in progress
//   MAC_DONE   one-cycle completion pulse
interface mac_sequencer_if #(
  parameter int NUM_PE = 4
);
  logic              START;
  logic [1:0]        DIMEN;
  logic              STALL;
  logic [1:0]        RD_ADDR_A;
  logic [3:0]        RD_ADDR_B;
  logic [NUM_PE-1:0] MAC_EN;
  logic              ACC_CLR;
  logic [1:0]        WR_ADDR_C;
  logic [NUM_PE-1:0] WR_EN_C;
  logic              BUSY;
  logic              MAC_DONE;

  modport master (
    output START, DIMEN, STALL,
    input  RD_ADDR_A, RD_ADDR_B, MAC_EN, ACC_CLR, WR_ADDR_C, WR_EN_C, BUSY, MAC_DONE
  );

  modport slave (
    input  START, DIMEN, STALL,
    output RD_ADDR_A, RD_ADDR_B, MAC_EN, ACC_CLR, WR_ADDR_C, WR_EN_C, BUSY, MAC_DONE
  );
endinterface

// File: rtl/mac_sequencer.sv
// MAC sequencer for one MULTACC instruction (C = A x B, N x N, N = DIMEN+1).
// Walks j (C column) in the outer loop and k (dot-product index) in the inner
// loop, issuing register-file read addresses and pushing a token per issue
// into a delay line matched to the register-file read latency. The token
// drives MAC_EN/ACC_CLR RD_LAT cycles after issue and the C write-back one
// cycle later. All outputs are registered.
// Ports:
//   CLK   clock
//   RSTN  synchronous reset, active-high (asserted = 1)
//   bus   mac_sequencer_if.slave (START/DIMEN/STALL in, addresses/strobes/status out)
module mac_sequencer #(
  parameter int RD_LAT = 1,
  parameter int NUM_PE = 4
) (
  input logic            CLK,
  input logic            RSTN,
  mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] dimen_q;
  logic [1:0] j_cnt;
  logic [1:0] k_cnt;

  // Token delay line: index 0 is written on the issue edge, index RD_LAT-1
  // feeds the MAC stage, index RD_LAT feeds the write-back stage.
  logic [RD_LAT:0] vld_p;
  logic [RD_LAT:0] first_p;
  logic [RD_LAT:0] last_p;
  logic [1:0]      j_p [0:RD_LAT];

  // PEs beyond N are left idle.
  function automatic logic [NUM_PE-1:0] pe_mask(input logic [1:0] dimen);
    logic [NUM_PE-1:0] m;
    for (int p = 0; p < NUM_PE; p++) m[p] = (p <= int'(dimen));
    return m;
  endfunction

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state         <= S_IDLE;
      dimen_q       <= '0;
      j_cnt         <= '0;
      k_cnt         <= '0;
      vld_p         <= '0;
      first_p       <= '0;
      last_p        <= '0;
      for (int i = 0; i <= RD_LAT; i++) j_p[i] <= '0;
      bus.RD_ADDR_A <= '0;
      bus.RD_ADDR_B <= '0;
      bus.MAC_EN    <= '0;
      bus.ACC_CLR   <= 1'b0;
      bus.WR_ADDR_C <= '0;
      bus.WR_EN_C   <= '0;
      bus.BUSY      <= 1'b0;
      bus.MAC_DONE  <= 1'b0;
    end else if (bus.STALL && (state != S_IDLE)) begin
      // Everything holds; strobes are suppressed so the held token fires
      // exactly once, on the first non-stalled edge.
      bus.MAC_EN   <= '0;
      bus.WR_EN_C  <= '0;
      bus.MAC_DONE <= 1'b0;
    end else begin
      // Issue stage -> delay line entry 0
      vld_p[0]   <= (state == S_ISSUE);
      first_p[0] <= (k_cnt == 2'd0);
      last_p[0]  <= (k_cnt == dimen_q);
      j_p[0]     <= j_cnt;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
        j_p[i]     <= j_p[i-1];
      end

      // MAC stage: operands arrive RD_LAT cycles after issue
      bus.MAC_EN  <= vld_p[RD_LAT-1] ? pe_mask(dimen_q) : '0;
      bus.ACC_CLR <= vld_p[RD_LAT-1] & first_p[RD_LAT-1];

      // Write-back stage: one cycle after the final MAC of a column
      bus.WR_EN_C <= (vld_p[RD_LAT] & last_p[RD_LAT]) ? pe_mask(dimen_q) : '0;
      if (vld_p[RD_LAT] & last_p[RD_LAT]) bus.WR_ADDR_C <= j_p[RD_LAT];

      bus.MAC_DONE <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.START) begin
            dimen_q  <= bus.DIMEN;
            j_cnt    <= '0;
            k_cnt    <= '0;
            bus.BUSY <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.RD_ADDR_A <= k_cnt;
          bus.RD_ADDR_B <= {k_cnt, j_cnt};
          if (k_cnt == dimen_q) begin
            k_cnt <= '0;
            if (j_cnt == dimen_q) state <= S_DRAIN;
            else                  j_cnt <= j_cnt + 2'd1;
          end else begin
            k_cnt <= k_cnt + 2'd1;
          end
        end
        S_DRAIN: begin
          // Pre-edge view: empty means the last write-back has already fired.
          if (vld_p == '0) begin
            bus.MAC_DONE <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          bus.BUSY <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: table of MULTACC runs checked cycle by cycle
// against a scoreboard of expected outputs, plus reset sequences.
module tb_mac_sequencer;

  localparam int RD_LAT = 1;

  logic CLK;
  logic RSTN;
  int   checks;
  int   failures;

  mac_sequencer_if #(.NUM_PE(4)) bus ();

  mac_sequencer #(.RD_LAT(RD_LAT), .NUM_PE(4)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       iss;
    logic [1:0] ra;
    logic [3:0] rb;
    logic [3:0] mac;
    logic       clr;
    logic [3:0] wr;
    logic [1:0] wa;
    logic       done;
  } exp_t;

  typedef struct {
    logic [1:0] dimen;
    logic       st0;           // STALL high on the START edge (IDLE)
    int         stall_at;      // first stalled edge relative to START edge
    int         stall_len;
    int         restart_at;    // edge at which a second START is offered (0 = none)
    logic       start_in_done; // offer START on the DONE-state edge
    int         done_rel;      // expected MAC_DONE cycle relative to START edge
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr_a"}, 32'(bus.RD_ADDR_A), 0);
    chk({tag, "_rd_addr_b"}, 32'(bus.RD_ADDR_B), 0);
    chk({tag, "_mac_en"},    32'(bus.MAC_EN), 0);
    chk({tag, "_acc_clr"},   32'(bus.ACC_CLR), 0);
    chk({tag, "_wr_addr_c"}, 32'(bus.WR_ADDR_C), 0);
    chk({tag, "_wr_en_c"},   32'(bus.WR_EN_C), 0);
    chk({tag, "_busy"},      32'(bus.BUSY), 0);
    chk({tag, "_mac_done"},  32'(bus.MAC_DONE), 0);
  endtask

  // Expected output stream indexed by non-stalled edge number after START.
  task automatic build_expect(input logic [1:0] dimen);
    exp_t tab [0:31];
    int n;
    int total;
    logic [3:0] m;
    n = int'(dimen) + 1;
    total = n * n + RD_LAT + 2;
    m = 4'((1 << n) - 1);
    for (int a = 0; a < 32; a++) tab[a] = '{default: '0};
    for (int i = 0; i < n * n; i++) begin
      int j;
      int k;
      j = i / n;
      k = i % n;
      tab[i+1].iss = 1'b1;
      tab[i+1].ra  = 2'(k);
      tab[i+1].rb  = 4'(k * 4 + j);
      tab[i+1+RD_LAT].mac = m;
      tab[i+1+RD_LAT].clr = (k == 0);
      if (k == n - 1) begin
        tab[i+2+RD_LAT].wr = m;
        tab[i+2+RD_LAT].wa = 2'(j);
      end
    end
    tab[total].done = 1'b1;
    sb.delete();
    for (int a = 1; a <= total; a++) sb.push_back(tab[a]);
  endtask

  task automatic run_case(input vec_t v);
    exp_t e;
    int   done_cnt;
    int   done_rel;
    logic stl;
    done_cnt = 0;
    done_rel = -1;
    bus.DIMEN = v.dimen;
    bus.STALL = v.st0;
    bus.START = 1'b1;
    build_expect(v.dimen);
    step();
    bus.START = 1'b0;
    bus.DIMEN = 2'd3;
    chk("busy_on_accept", 32'(bus.BUSY), 1);
    for (int rel = 1; rel <= v.done_rel + 1; rel++) begin
      stl = (v.stall_len > 0) && (rel >= v.stall_at) && (rel < v.stall_at + v.stall_len);
      bus.STALL = stl;
      bus.START = (rel == v.restart_at) ||
                  (v.start_in_done && done_cnt == 1 && rel == done_rel + 1);
      step();
      if (stl) begin
        chk("stall_mac_en",   32'(bus.MAC_EN), 0);
        chk("stall_wr_en_c",  32'(bus.WR_EN_C), 0);
        chk("stall_mac_done", 32'(bus.MAC_DONE), 0);
        chk("stall_busy",     32'(bus.BUSY), 1);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("mac_en",   32'(bus.MAC_EN), 32'(e.mac));
        chk("wr_en_c",  32'(bus.WR_EN_C), 32'(e.wr));
        chk("mac_done", 32'(bus.MAC_DONE), 32'(e.done));
        chk("busy",     32'(bus.BUSY), 1);
        if (e.iss) begin
          chk("rd_addr_a", 32'(bus.RD_ADDR_A), 32'(e.ra));
          chk("rd_addr_b", 32'(bus.RD_ADDR_B), 32'(e.rb));
        end
        if (e.mac != 4'd0) chk("acc_clr", 32'(bus.ACC_CLR), 32'(e.clr));
        if (e.wr != 4'd0)  chk("wr_addr_c", 32'(bus.WR_ADDR_C), 32'(e.wa));
      end else begin
        chk("idle_busy",     32'(bus.BUSY), 0);
        chk("idle_mac_en",   32'(bus.MAC_EN), 0);
        chk("idle_wr_en_c",  32'(bus.WR_EN_C), 0);
        chk("idle_mac_done", 32'(bus.MAC_DONE), 0);
      end
      if (bus.MAC_DONE) begin
        done_cnt++;
        done_rel = rel;
      end
    end
    bus.START = 1'b0;
    bus.STALL = 1'b0;
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_rel), 32'(v.done_rel));
    step();
    chk("after_busy",   32'(bus.BUSY), 0);
    chk("after_mac_en", 32'(bus.MAC_EN), 0);
  endtask

  task automatic abort_case();
    int noisy;
    bus.DIMEN = 2'd3;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int rel = 1; rel <= 8; rel++) step();
    chk("pre_abort_mac_en", 32'(bus.MAC_EN), 32'hF);
    chk("pre_abort_busy",   32'(bus.BUSY), 1);
    RSTN = 1'b1;
    step();
    chk_all_zero("abort");
    RSTN = 1'b0;
    noisy = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.WR_EN_C != 4'd0 || bus.MAC_EN != 4'd0 || bus.MAC_DONE || bus.BUSY) noisy++;
    end
    chk("abort_quiet_cycles", 32'(noisy), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTN      = 1'b1;
    bus.START = 1'b0;
    bus.DIMEN = 2'd0;
    bus.STALL = 1'b0;

    //           dimen st0  stall_at len restart done_start done_rel
    vecs[0] = '{2'd3, 1'b0, 0, 0, 0, 1'b0, 19};
    vecs[1] = '{2'd1, 1'b0, 0, 0, 0, 1'b0, 7};
    vecs[2] = '{2'd0, 1'b1, 0, 0, 0, 1'b0, 4};
    vecs[3] = '{2'd3, 1'b0, 6, 3, 0, 1'b0, 22};
    vecs[4] = '{2'd1, 1'b0, 0, 0, 3, 1'b1, 7};
    vecs[5] = '{2'd2, 1'b0, 5, 2, 0, 1'b0, 14};

    step();
    step();
    chk_all_zero("reset");
    RSTN = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      run_case(vecs[t]);
      step();
    end

    abort_case();
    run_case(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
